// File: rtl/attn_ctrl_regs.sv
// AXI4-Lite control/status register block for the self-attention accelerator.
// Optional cycle counter compiled in only when ATTN_PERF_CNT_EN is defined.
module attn_ctrl_regs #(
   parameter int AXIL_ADDR_WIDTH = 12,
   parameter int N_ADDR          = 10
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [31:0]                s_axil_wdata,
   input  logic [3:0]                 s_axil_wstrb,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   output logic [1:0]                 s_axil_bresp,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic                       s_axil_arvalid,
   output logic                       s_axil_arready,
   output logic [31:0]                s_axil_rdata,
   output logic [1:0]                 s_axil_rresp,
   output logic                       s_axil_rvalid,
   input  logic                       s_axil_rready,
   output logic                       attn_start,
   input  logic                       attn_done,
   input  logic                       attn_error,
   output logic [64*N_ADDR-1:0]       cfg_addr,
   output logic [127:0]               cfg_requant_m,
   output logic [31:0]                cfg_requant_e,
   output logic [159:0]               cfg_softmax,
   output logic                       irq
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [63:0] r_addr [N_ADDR];
   logic [31:0] r_rq_m [4];
   logic [7:0]  r_rq_e [4];
   logic [31:0] r_sm   [5];

   logic        r_irq_en;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic        r_start;
   logic        r_done_q;
   logic        r_err_q;
   logic        r_bvalid;
   logic [1:0]  r_bresp;
   logic        r_rvalid;
   logic [1:0]  r_rresp;
   logic [31:0] r_rdata;

   logic [29:0] w_awi;
   logic [29:0] w_ari;
   logic        w_wmap;
   logic        w_wcfg;
   logic        w_rmap;
   logic [31:0] w_rval;
   logic [31:0] w_cycles;
   logic        w_wr_acc;
   logic        w_rd_acc;
   logic        w_start_req;
   logic        w_start_go;
   logic        w_blocked;
   logic        w_ctrl_wr;
   logic        w_clr_done;
   logic        w_clr_err;
   logic        w_done_rise;
   logic        w_err_rise;

   function automatic logic [31:0] f_merge(
      input logic [31:0] old,
      input logic [31:0] d,
      input logic [3:0]  s
   );
      logic [31:0] v;
      for (int b = 0; b < 4; b++) begin
         v[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
      end
      return v;
   endfunction

   // Word-granular decode; byte offset bits are ignored.
   assign w_awi = 30'(s_axil_awaddr >> 2);
   assign w_ari = 30'(s_axil_araddr >> 2);

   assign w_wr_acc = s_axil_awvalid & s_axil_wvalid & ~r_bvalid;
   assign w_rd_acc = s_axil_arvalid & ~r_rvalid;

   assign s_axil_awready = w_wr_acc;
   assign s_axil_wready  = w_wr_acc;
   assign s_axil_arready = w_rd_acc;
   assign s_axil_bvalid  = r_bvalid;
   assign s_axil_bresp   = r_bresp;
   assign s_axil_rvalid  = r_rvalid;
   assign s_axil_rresp   = r_rresp;
   assign s_axil_rdata   = r_rdata;

   assign w_ctrl_wr   = w_wr_acc && (w_awi == 30'd0) && s_axil_wstrb[0];
   assign w_start_req = (w_awi == 30'd0) && s_axil_wstrb[0]
                      && s_axil_wdata[0];
   assign w_start_go  = w_wr_acc && w_start_req && !r_busy;
   assign w_blocked   = r_busy && (w_wcfg || w_start_req);

   assign w_clr_done = w_wr_acc && (w_awi == 30'd1)
                     && s_axil_wstrb[0] && s_axil_wdata[1];
   assign w_clr_err  = w_wr_acc && (w_awi == 30'd1)
                     && s_axil_wstrb[0] && s_axil_wdata[2];

   assign w_done_rise = attn_done & ~r_done_q;
   assign w_err_rise  = attn_error & ~r_err_q;

   assign attn_start = r_start;
   assign irq        = (r_done | r_err) & r_irq_en;

   always_comb begin
      w_wmap = 1'b0;
      w_wcfg = 1'b0;
      if (w_awi == 30'd0 || w_awi == 30'd1 || w_awi == 30'd2) begin
         w_wmap = 1'b1;
      end
      for (int i = 0; i < N_ADDR; i++) begin
         if (w_awi == 30'(64 + 2*i) || w_awi == 30'(65 + 2*i)) begin
            w_wmap = 1'b1;
            w_wcfg = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (w_awi == 30'(128 + i) || w_awi == 30'(132 + i)) begin
            w_wmap = 1'b1;
            w_wcfg = 1'b1;
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (w_awi == 30'(192 + i)) begin
            w_wmap = 1'b1;
            w_wcfg = 1'b1;
         end
      end
   end

   always_comb begin
      w_rmap = 1'b0;
      w_rval = '0;
      if (w_ari == 30'd0) begin
         w_rmap = 1'b1;
         w_rval = {30'd0, r_irq_en, 1'b0};
      end else if (w_ari == 30'd1) begin
         w_rmap = 1'b1;
         w_rval = {29'd0, r_err, r_done, r_busy};
      end else if (w_ari == 30'd2) begin
         w_rmap = 1'b1;
         w_rval = w_cycles;
      end
      for (int i = 0; i < N_ADDR; i++) begin
         if (w_ari == 30'(64 + 2*i)) begin
            w_rmap = 1'b1;
            w_rval = r_addr[i][31:0];
         end
         if (w_ari == 30'(65 + 2*i)) begin
            w_rmap = 1'b1;
            w_rval = r_addr[i][63:32];
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (w_ari == 30'(128 + i)) begin
            w_rmap = 1'b1;
            w_rval = r_rq_m[i];
         end
         if (w_ari == 30'(132 + i)) begin
            w_rmap = 1'b1;
            w_rval = {24'd0, r_rq_e[i]};
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (w_ari == 30'(192 + i)) begin
            w_rmap = 1'b1;
            w_rval = r_sm[i];
         end
      end
   end

   // Configuration is frozen while a run is in flight.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < N_ADDR; i++) r_addr[i] <= '0;
         for (int i = 0; i < 4; i++) begin
            r_rq_m[i] <= '0;
            r_rq_e[i] <= '0;
         end
         for (int i = 0; i < 5; i++) r_sm[i] <= '0;
      end else if (w_wr_acc && !r_busy) begin
         for (int i = 0; i < N_ADDR; i++) begin
            if (w_awi == 30'(64 + 2*i)) begin
               r_addr[i][31:0] <= f_merge(r_addr[i][31:0],
                                          s_axil_wdata, s_axil_wstrb);
            end
            if (w_awi == 30'(65 + 2*i)) begin
               r_addr[i][63:32] <= f_merge(r_addr[i][63:32],
                                           s_axil_wdata, s_axil_wstrb);
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (w_awi == 30'(128 + i)) begin
               r_rq_m[i] <= f_merge(r_rq_m[i], s_axil_wdata, s_axil_wstrb);
            end
            if (w_awi == 30'(132 + i) && s_axil_wstrb[0]) begin
               r_rq_e[i] <= s_axil_wdata[7:0];
            end
         end
         for (int i = 0; i < 5; i++) begin
            if (w_awi == 30'(192 + i)) begin
               r_sm[i] <= f_merge(r_sm[i], s_axil_wdata, s_axil_wstrb);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_irq_en <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_start  <= 1'b0;
         r_done_q <= 1'b0;
         r_err_q  <= 1'b0;
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= '0;
      end else begin
         r_done_q <= attn_done;
         r_err_q  <= attn_error;
         r_start  <= w_start_go;
         if (w_start_go) begin
            r_busy <= 1'b1;
         end else if (w_done_rise || w_err_rise) begin
            r_busy <= 1'b0;
         end
         // A completion edge wins over a W1C in the same cycle.
         r_done <= (r_done & ~w_clr_done) | w_done_rise;
         r_err  <= (r_err & ~w_clr_err) | w_err_rise;
         if (w_ctrl_wr) begin
            r_irq_en <= s_axil_wdata[1];
         end
         if (w_wr_acc) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (w_wmap && !w_blocked) ? RESP_OKAY : RESP_SLVERR;
         end else if (r_bvalid && s_axil_bready) begin
            r_bvalid <= 1'b0;
         end
         if (w_rd_acc) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rval;
            r_rresp  <= w_rmap ? RESP_OKAY : RESP_SLVERR;
         end else if (r_rvalid && s_axil_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

`ifdef ATTN_PERF_CNT_EN
   logic [31:0] r_cycles;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cycles <= '0;
      end else if (w_start_go) begin
         r_cycles <= '0;
      end else if (r_busy && r_cycles != 32'hFFFF_FFFF) begin
         r_cycles <= r_cycles + 32'd1;
      end
   end

   assign w_cycles = r_cycles;
`else
   assign w_cycles = '0;
`endif

   for (genvar g = 0; g < N_ADDR; g++) begin : g_addr
      assign cfg_addr[64*g +: 64] = r_addr[g];
   end

   for (genvar g = 0; g < 4; g++) begin : g_rq
      assign cfg_requant_m[32*g +: 32] = r_rq_m[g];
      assign cfg_requant_e[8*g +: 8]   = r_rq_e[g];
   end

   for (genvar g = 0; g < 5; g++) begin : g_sm
      assign cfg_softmax[32*g +: 32] = r_sm[g];
   end

endmodule
